// File: rtl/ahb_sram_if_if.sv
// AHB-Lite bus bundle for the SRAM front end: address/data-phase inputs from the
// master side, ready/response/read data back from the slave.
interface ahb_sram_if_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_if.sv
// AHB-Lite slave front end for the on-chip SRAM: reads issue in the address phase, writes land
// in the data phase. Define AHB_SRAM_RAW_STALL_EN to add a read-after-write wait state.
module ahb_sram_if #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  ahb_sram_if_if.slave          bus,
  output logic [31:0]           sram_writedata,
  output logic [3:0]            sram_wren,
  output logic [ADDR_WIDTH-3:0] sram_writeaddr,
  output logic                  sram_rden,
  output logic [ADDR_WIDTH-3:0] sram_readaddr,
  input  logic [31:0]           sram_readdata
);

  typedef enum logic [2:0] {
    IDLE,
    WR_DP,
    RD_DP,
    ERR1,
    ERR2
`ifdef AHB_SRAM_RAW_STALL_EN
    , RAW_WAIT
`endif
  } state_t;

  state_t                  state_reg;
  logic                    hreadyout_reg;
  logic                    hresp_reg;
  logic [3:0]              lane_reg;
  logic [ADDR_WIDTH-3:0]   waddr_reg;

  logic [3:0]              lane_mask;
  logic [ADDR_WIDTH-3:0]   word_idx;
  logic                    req;
  logic                    legal;
  logic                    raw_hazard;
  logic                    ready_int;
  logic                    accept;
  logic                    acc_wr;
  logic                    acc_rd;
  logic                    acc_err;
  logic                    unused_bits;

  // Address bits above the SRAM window alias; htrans[0] only separates NONSEQ from SEQ.
  assign unused_bits = &{1'b0, bus.haddr[31:ADDR_WIDTH], bus.htrans[0]};

  assign word_idx = bus.haddr[ADDR_WIDTH-1:2];
  assign req      = bus.hsel & bus.htrans[1];
  assign legal    = (bus.hsize == 3'd0)
                  | ((bus.hsize == 3'd1) & ~bus.haddr[0])
                  | ((bus.hsize == 3'd2) & (bus.haddr[1:0] == 2'b00));

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_mask[gi] = (bus.hsize == 3'd2)
                           | ((bus.hsize == 3'd1) & (bus.haddr[1] == (gi >= 2)))
                           | ((bus.hsize == 3'd0) & (bus.haddr[1:0] == 2'(gi)));
    end
  endgenerate

`ifdef AHB_SRAM_RAW_STALL_EN
  // hready is left out so hreadyout never depends combinationally on the bus ready it feeds.
  assign raw_hazard = (state_reg == WR_DP) & req & ~bus.hwrite & legal & (word_idx == waddr_reg);
`else
  assign raw_hazard = 1'b0;
`endif

  assign ready_int = hreadyout_reg & ~raw_hazard;
  assign accept    = req & bus.hready & ready_int;
  assign acc_wr    = accept & legal & bus.hwrite;
  assign acc_rd    = accept & legal & ~bus.hwrite;
  assign acc_err   = accept & ~legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      hreadyout_reg <= 1'b1;
      hresp_reg     <= 1'b0;
      lane_reg      <= 4'b0000;
      waddr_reg     <= '0;
    end else begin
      hreadyout_reg <= 1'b1;
      hresp_reg     <= 1'b0;
`ifdef AHB_SRAM_RAW_STALL_EN
      if (raw_hazard) begin
        state_reg <= RAW_WAIT;
      end else
`endif
      if (state_reg == ERR1) begin
        state_reg <= ERR2;
        hresp_reg <= 1'b1;
      end else if (acc_wr) begin
        state_reg <= WR_DP;
        lane_reg  <= lane_mask;
        waddr_reg <= word_idx;
      end else if (acc_rd) begin
        state_reg <= RD_DP;
      end else if (acc_err) begin
        state_reg     <= ERR1;
        hreadyout_reg <= 1'b0;
        hresp_reg     <= 1'b1;
      end else begin
        state_reg <= IDLE;
      end
    end
  end

  assign bus.hreadyout  = ready_int;
  assign bus.hresp      = hresp_reg;
  assign bus.hrdata     = (state_reg == RD_DP) ? sram_readdata : 32'h0;

  assign sram_writedata = bus.hwdata;
  assign sram_wren      = (state_reg == WR_DP) ? lane_reg : 4'b0000;
  assign sram_writeaddr = waddr_reg;
  assign sram_rden      = acc_rd;
  assign sram_readaddr  = word_idx;

endmodule

// File: tb/tb_ahb_sram_if.sv
// Bench for ahb_sram_if: directed AHB scenarios plus random traffic, all checked
// against a transaction-level model of the bus pipeline and memory contents.
module tb_ahb_sram_if;
  localparam int AW = 16;
  localparam int NW = 1 << (AW - 2);
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ahb_sram_if_if bus ();

  logic [31:0]   sram_writedata;
  logic [3:0]    sram_wren;
  logic [AW-3:0] sram_writeaddr;
  logic          sram_rden;
  logic [AW-3:0] sram_readaddr;
  logic [31:0]   sram_readdata;

  ahb_sram_if #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .sram_writedata (sram_writedata),
    .sram_wren      (sram_wren),
    .sram_writeaddr (sram_writeaddr),
    .sram_rden      (sram_rden),
    .sram_readaddr  (sram_readaddr),
    .sram_readdata  (sram_readdata)
  );

  // SRAM stand-in: registered read, new write data visible to a same-cycle read.
  bit [31:0] sram_mem [NW];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (|sram_wren)
      sram_mem[sram_writeaddr] <= merge(sram_mem[sram_writeaddr], sram_writedata, sram_wren);
    if (sram_rden)
      sram_readdata <= (sram_writeaddr == sram_readaddr)
                     ? merge(sram_mem[sram_readaddr], sram_writedata, sram_wren)
                     : sram_mem[sram_readaddr];
  end

  // Reference model: what the pending data phase is, and what memory should hold.
  typedef enum {PH_NONE, PH_WR, PH_RD, PH_ERR1, PH_ERR2} phase_t;
  phase_t      ph = PH_NONE;
  int unsigned ph_idx = 0;
  logic [3:0]  ph_mask = 4'b0000;
  bit [31:0]   ref_mem [NW];
  int          checks = 0;
  int          failures = 0;
  logic        last_rdy = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic bit legal_of(input logic [2:0] size, input logic [31:0] a);
    if (size > 3'd2) return 1'b0;
    return (int'(a[1:0]) % (1 << size)) == 0;
  endfunction

  function automatic logic [3:0] mask_of(input logic [2:0] size, input logic [31:0] a);
    case (size)
      3'd0:    return 4'b0001 << a[1:0];
      3'd1:    return 4'b0011 << a[1:0];
      default: return 4'b1111;
    endcase
  endfunction

  // One bus cycle: drive, check against the model mid-cycle, then advance the model.
  task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr, input logic rdy,
                      input logic [31:0] wdata);
    bit          lg, stall, exp_rdy, acc;
    int unsigned idx;
    bus.hsel = sel; bus.htrans = trans; bus.hwrite = wr; bus.hsize = size;
    bus.haddr = addr; bus.hready = rdy; bus.hwdata = wdata;
    @(negedge clk);
    lg    = legal_of(size, addr);
    idx   = int'(addr[AW-1:2]);
    stall = 1'b0;
`ifdef AHB_SRAM_RAW_STALL_EN
    stall = (ph == PH_WR) && sel && trans[1] && !wr && lg && (idx == ph_idx);
`endif
    exp_rdy = (ph != PH_ERR1) && !stall;
    acc     = sel && trans[1] && rdy && exp_rdy;
    check("hreadyout", bus.hreadyout, exp_rdy);
    check("hresp", bus.hresp, (ph == PH_ERR1) || (ph == PH_ERR2));
    check("wren", sram_wren, (ph == PH_WR) ? ph_mask : 4'b0000);
    check("hrdata", bus.hrdata, (ph == PH_RD) ? ref_mem[ph_idx] : 32'h0);
    check("rden", sram_rden, acc && lg && !wr);
    if (ph == PH_WR) begin
      check("writeaddr", sram_writeaddr, ph_idx);
      check("writedata", sram_writedata, wdata);
    end
    if (acc && lg && !wr) check("readaddr", sram_readaddr, idx);
    if (acc) $display("txn t=%0t %s addr=%08h size=%0d %s", $time, wr ? "WR" : "RD", addr, size,
                      lg ? "ok" : "error");
    last_rdy = exp_rdy;
    @(posedge clk);
    if (ph == PH_WR) ref_mem[ph_idx] = merge(ref_mem[ph_idx], wdata, ph_mask);
    if (ph == PH_ERR1) ph = PH_ERR2;
    else if (acc && lg) begin
      ph = wr ? PH_WR : PH_RD; ph_idx = idx; ph_mask = mask_of(size, addr);
    end
    else if (acc) ph = PH_ERR1;
    else ph = PH_NONE;
    #1;
  endtask

  // Repeat the address phase while the slave holds it off (bounded).
  task automatic xfer(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr, input logic rdy,
                      input logic [31:0] wdata);
    int tries = 0;
    do begin
      step(sel, trans, wr, size, addr, rdy, wdata);
      tries++;
    end while (!last_rdy && tries < 4);
    check("stall_bound", 32'(!last_rdy), 32'd0);
  endtask

  task automatic idle(input logic [31:0] wdata);
    xfer(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 1'b1, wdata);
  endtask

  logic        r_sel, r_wr, r_rdy;
  logic [1:0]  r_trans;
  logic [2:0]  r_size;
  logic [31:0] r_addr;

  initial begin
    bus.hsel = 0; bus.htrans = 0; bus.hwrite = 0; bus.hsize = 0;
    bus.haddr = 0; bus.hready = 1; bus.hwdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hreadyout", bus.hreadyout, 1'b1);
    check("rst_hresp", bus.hresp, 1'b0);
    check("rst_hrdata", bus.hrdata, 32'h0);
    check("rst_wren", sram_wren, 4'b0000);
    check("rst_rden", sram_rden, 1'b0);
    check("rst_writeaddr", sram_writeaddr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Word write then read back
    xfer(1, NONSEQ, 1, 3'd2, 32'h0000_0010, 1, 32'h0);
    xfer(1, NONSEQ, 0, 3'd2, 32'h0000_0010, 1, 32'h1234_5678);
    idle(32'h0);
    // Byte writes into a zero word, then full-word read
    xfer(1, NONSEQ, 1, 3'd0, 32'h0000_0021, 1, 32'h0);
    xfer(1, SEQ,    1, 3'd0, 32'h0000_0022, 1, 32'h0000_AA00);
    xfer(1, NONSEQ, 0, 3'd2, 32'h0000_0020, 1, 32'h00BB_0000);
    idle(32'h0);
    check("byte_merge", ref_mem[8], 32'h00BB_AA00);
    // Misaligned halfword: two-cycle error, no write
    xfer(1, NONSEQ, 1, 3'd1, 32'h0000_0003, 1, 32'h0);
    idle(32'hFFFF_FFFF);
    idle(32'hFFFF_FFFF);
    xfer(1, NONSEQ, 0, 3'd2, 32'h0000_0000, 1, 32'h0);
    idle(32'h0);
    // Back-to-back write/read of the same word
    xfer(1, NONSEQ, 1, 3'd2, 32'h0000_0040, 1, 32'h0);
    xfer(1, NONSEQ, 0, 3'd2, 32'h0000_0040, 1, 32'hDEAD_BEEF);
    idle(32'h0);
    check("raw_data", ref_mem[16], 32'hDEAD_BEEF);
    // hready low from another slave: transfer ignored
    xfer(1, NONSEQ, 1, 3'd2, 32'h0000_0044, 0, 32'h0);
    idle(32'h5555_5555);
    // Reset during a write data phase drops the write
    xfer(1, NONSEQ, 1, 3'd2, 32'h0000_0080, 1, 32'h0);
    idle(32'hCAFE_F00D);
    xfer(1, NONSEQ, 1, 3'd2, 32'h0000_0080, 1, 32'hCAFE_F00D);
    bus.hsel = 0; bus.htrans = 0; bus.hwdata = 32'h1111_1111;
    reset = 1'b1;
    #1;
    check("rst_mid_wren", sram_wren, 4'b0000);
    check("rst_mid_hreadyout", bus.hreadyout, 1'b1);
    ph = PH_NONE;
    @(posedge clk); #1;
    reset = 1'b0;
    xfer(1, NONSEQ, 0, 3'd2, 32'h0000_0080, 1, 32'h0);
    idle(32'h0);
    check("rst_old_value", ref_mem[32], 32'hCAFE_F00D);

    // Random traffic over a few aliased words
    r_sel = 0; r_trans = 0; r_wr = 0; r_size = 0; r_addr = 0; r_rdy = 1;
    for (int n = 0; n < 600; n++) begin
      if (last_rdy) begin
        r_sel   = ($urandom_range(0, 9) != 0);
        r_trans = 2'($urandom_range(0, 3));
        r_wr    = 1'($urandom_range(0, 1));
        r_size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        r_addr  = ($urandom() & 32'hFFFF_0000) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
      end
      r_rdy = !((ph == PH_NONE) && ($urandom_range(0, 6) == 0));
      step(r_sel, r_trans, r_wr, r_size, r_addr, r_rdy, $urandom());
    end
    idle(32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
